// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter: queues tensor writeback results and issues them in
// FIFO order onto the register files' force-write port. Issue is held off
// during UPDATE when a normal register write is pending. A per-register
// pending mask covers every destination that is still in flight.
//
// Handshake: a transfer happens on a rising clk edge when enq_valid and
// enq_ready are both 1. enq_ready depends only on registered occupancy.
// enq_valid may rise without waiting for enq_ready. The source holds
// enq_dest and enq_data stable until the transfer completes.
module reg_writeback_arbiter #(
    parameter int THREADS   = 4,
    parameter int DATA_BITS = 16,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [3:0]                   enq_dest,
    input  logic [THREADS*DATA_BITS-1:0] enq_data,
    input  logic [2:0]                   core_state,
    input  logic                         decoded_reg_write_enable,
    output logic                         force_reg_write_enable,
    output logic [3:0]                   force_reg_write_dest,
    output logic [THREADS*DATA_BITS-1:0] force_reg_write_data,
    output logic [15:0]                  pending_mask,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count,
    output logic                         err_illegal_dest
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int LW = THREADS*DATA_BITS;
    localparam logic [2:0] CORE_UPDATE = 3'b110;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [3:0]    dest_mem [DEPTH];
    logic [LW-1:0] data_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] reg_cnt [16];

    logic enq_fire;
    logic dest_legal;
    logic push;
    logic empty;
    logic blocked;
    logic issue;
    logic [3:0] head_dest;

    // Handshake, legality and issue decisions for the current cycle.
    always_comb begin
        enq_ready  = (count < DEPTH_C);
        enq_fire   = enq_valid && enq_ready;
        dest_legal = (enq_dest != 4'd0) && (enq_dest <= 4'd12);
        push       = enq_fire && dest_legal && !flush && !reset;
        empty      = (count == '0);
        blocked    = (core_state == CORE_UPDATE) && decoded_reg_write_enable;
        issue      = !empty && !blocked && !flush && !reset;
        head_dest  = dest_mem[rd_ptr];
    end

    // Force-write port is driven straight from the head entry.
    always_comb begin
        force_reg_write_enable = issue;
        force_reg_write_dest   = empty ? 4'd0 : head_dest;
        force_reg_write_data   = empty ? '0 : data_mem[rd_ptr];
        queue_count            = count;
    end

    // Pointers and occupancy. Flush or reset drops every entry at once.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (issue)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !issue)
                count <= count + 1'b1;
            else if (!push && issue)
                count <= count - 1'b1;
        end
    end

    // Entry storage. Stale slots are never read because the empty check gates them.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_mem[wr_ptr] <= enq_dest;
            data_mem[wr_ptr] <= enq_data;
        end
    end

    // Per-register in-flight counters. An enqueue and a pop to the same register cancel out.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int r = 0; r < 16; r++)
                reg_cnt[r] <= '0;
        end else begin
            for (int r = 0; r < 16; r++) begin
                if ((push && enq_dest == 4'(r)) && !(issue && head_dest == 4'(r)))
                    reg_cnt[r] <= reg_cnt[r] + 1'b1;
                else if (!(push && enq_dest == 4'(r)) && (issue && head_dest == 4'(r)))
                    reg_cnt[r] <= reg_cnt[r] - 1'b1;
            end
        end
    end

    // Pending mask covers legal destinations only. Register 0 and registers 13-15 read as 0.
    always_comb begin
        pending_mask = '0;
        for (int r = 1; r <= 12; r++)
            pending_mask[r] = (reg_cnt[r] != '0);
    end

    // Sticky error for rejected destinations. Only reset clears it.
    always_ff @(posedge clk) begin
        if (reset)
            err_illegal_dest <= 1'b0;
        else if (enq_fire && !dest_legal)
            err_illegal_dest <= 1'b1;
    end

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed bench for reg_writeback_arbiter. Inputs change on the falling edge,
// and outputs are sampled 1 ns later, well away from the rising edge.
module tb_reg_writeback_arbiter;

    localparam int THREADS   = 4;
    localparam int DATA_BITS = 16;
    localparam int DEPTH     = 4;
    localparam int LW        = THREADS*DATA_BITS;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          enq_valid;
    logic          enq_ready;
    logic [3:0]    enq_dest;
    logic [LW-1:0] enq_data;
    logic [2:0]    core_state;
    logic          decoded_reg_write_enable;
    logic          force_reg_write_enable;
    logic [3:0]    force_reg_write_dest;
    logic [LW-1:0] force_reg_write_data;
    logic [15:0]   pending_mask;
    logic [2:0]    queue_count;
    logic          err_illegal_dest;

    int n_chk = 0;
    int n_bad = 0;

    reg_writeback_arbiter #(.THREADS(THREADS), .DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .flush                    (flush),
        .enq_valid                (enq_valid),
        .enq_ready                (enq_ready),
        .enq_dest                 (enq_dest),
        .enq_data                 (enq_data),
        .core_state               (core_state),
        .decoded_reg_write_enable (decoded_reg_write_enable),
        .force_reg_write_enable   (force_reg_write_enable),
        .force_reg_write_dest     (force_reg_write_dest),
        .force_reg_write_data     (force_reg_write_data),
        .pending_mask             (pending_mask),
        .queue_count              (queue_count),
        .err_illegal_dest         (err_illegal_dest)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "timeout");
    end

    // checking task
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic set_block(input logic b);
        core_state               = b ? 3'b110 : 3'b000;
        decoded_reg_write_enable = b;
    endtask

    task automatic enq_one(input logic [3:0] d, input logic [LW-1:0] v);
        enq_valid = 1'b1;
        enq_dest  = d;
        enq_data  = v;
        tick();
        enq_valid = 1'b0;
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".cnt"},  64'(queue_count), 64'd0);
        chk({tag, ".pm"},   64'(pending_mask), 64'd0);
        chk({tag, ".err"},  64'(err_illegal_dest), 64'd0);
        chk({tag, ".fen"},  64'(force_reg_write_enable), 64'd0);
        chk({tag, ".fdst"}, 64'(force_reg_write_dest), 64'd0);
        chk({tag, ".fdat"}, force_reg_write_data, 64'd0);
    endtask

    logic [3:0]    exp_dest [4];
    logic [LW-1:0] v;

    initial begin
        reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_dest = '0; enq_data = '0;
        set_block(1'b0);
        @(negedge clk);
        tick();
        reset = 1'b0;
        #1;
        chk_reset_vals("rst");
        chk("rst.rdy", 64'(enq_ready), 64'd1);

        // single write
        enq_one(4'd5, 64'h4444_3333_2222_1111);
        chk("sw.fen",  64'(force_reg_write_enable), 64'd1);
        chk("sw.fdst", 64'(force_reg_write_dest), 64'd5);
        chk("sw.fdat", force_reg_write_data, 64'h4444_3333_2222_1111);
        chk("sw.pm",   64'(pending_mask), 64'h0020);
        chk("sw.cnt",  64'(queue_count), 64'd1);
        tick();
        chk("sw.fen2", 64'(force_reg_write_enable), 64'd0);
        chk("sw.pm2",  64'(pending_mask), 64'd0);
        chk("sw.cnt2", 64'(queue_count), 64'd0);

        // UPDATE with a pending normal write blocks for one cycle
        set_block(1'b1);
        enq_one(4'd3, 64'h0003_0003_0003_0003);
        chk("upd.blk", 64'(force_reg_write_enable), 64'd0);
        chk("upd.cnt", 64'(queue_count), 64'd1);
        set_block(1'b0);
        #1;
        chk("upd.go",  64'(force_reg_write_enable), 64'd1);
        chk("upd.dst", 64'(force_reg_write_dest), 64'd3);
        tick();
        chk("upd.cnt0", 64'(queue_count), 64'd0);
        core_state = 3'b110; decoded_reg_write_enable = 1'b0;
        enq_one(4'd3, 64'h0033_0033_0033_0033);
        chk("updnw.fen", 64'(force_reg_write_enable), 64'd1);
        tick();
        chk("updnw.cnt", 64'(queue_count), 64'd0);
        set_block(1'b0);

        // fill and wrap, three rounds
        exp_dest[0] = 4'd1; exp_dest[1] = 4'd2; exp_dest[2] = 4'd1; exp_dest[3] = 4'd4;
        for (int r = 0; r < 3; r++) begin
            set_block(1'b1);
            for (int i = 0; i < 4; i++)
                enq_one(exp_dest[i], {4{16'(16'hA000 + r*16 + i)}});
            chk("fill.cnt", 64'(queue_count), 64'd4);
            chk("fill.rdy", 64'(enq_ready), 64'd0);
            chk("fill.pm",  64'(pending_mask), 64'h0016);
            chk("fill.fen", 64'(force_reg_write_enable), 64'd0);
            enq_one(4'd9, 64'h9999_9999_9999_9999);
            chk("fill.nacc", 64'(queue_count), 64'd4);
            chk("fill.pm9",  64'(pending_mask[9]), 64'd0);
            set_block(1'b0);
            #1;
            for (int i = 0; i < 4; i++) begin
                chk("drain.fen",  64'(force_reg_write_enable), 64'd1);
                chk("drain.fdst", 64'(force_reg_write_dest), 64'(exp_dest[i]));
                chk("drain.fdat", force_reg_write_data, {4{16'(16'hA000 + r*16 + i)}});
                chk("drain.pm1",  64'(pending_mask[1]), (i <= 2) ? 64'd1 : 64'd0);
                tick();
            end
            chk("drain.cnt", 64'(queue_count), 64'd0);
            chk("drain.pm",  64'(pending_mask), 64'd0);
        end

        // illegal destinations
        enq_one(4'd0, 64'h1);
        chk("ill0.err", 64'(err_illegal_dest), 64'd1);
        chk("ill0.cnt", 64'(queue_count), 64'd0);
        chk("ill0.fen", 64'(force_reg_write_enable), 64'd0);
        enq_one(4'd14, 64'h2);
        chk("ill14.cnt", 64'(queue_count), 64'd0);
        chk("ill14.pm",  64'(pending_mask), 64'd0);
        tick();
        tick();
        chk("ill.sticky", 64'(err_illegal_dest), 64'd1);

        // simultaneous enqueue and pop at count 3
        set_block(1'b1);
        enq_one(4'd7, 64'h7);
        enq_one(4'd8, 64'h8);
        enq_one(4'd9, 64'h9);
        set_block(1'b0);
        enq_valid = 1'b1; enq_dest = 4'd7; enq_data = 64'h77;
        #1;
        chk("sim.fen", 64'(force_reg_write_enable), 64'd1);
        chk("sim.dst", 64'(force_reg_write_dest), 64'd7);
        tick();
        enq_valid = 1'b0;
        #1;
        chk("sim.cnt", 64'(queue_count), 64'd3);
        chk("sim.pm",  64'(pending_mask), 64'h0380);
        chk("sim.d0", 64'(force_reg_write_dest), 64'd8);
        tick();
        chk("sim.d1", 64'(force_reg_write_dest), 64'd9);
        tick();
        chk("sim.d2",  64'(force_reg_write_dest), 64'd7);
        chk("sim.dat", force_reg_write_data, 64'h77);
        tick();
        chk("sim.cnt0", 64'(queue_count), 64'd0);

        // flush mid-stream, with a concurrent offer
        set_block(1'b1);
        enq_one(4'd2, 64'h2);
        enq_one(4'd3, 64'h3);
        enq_one(4'd4, 64'h4);
        set_block(1'b0);
        flush = 1'b1; enq_valid = 1'b1; enq_dest = 4'd5; enq_data = 64'h5;
        #1;
        chk("fl.fen", 64'(force_reg_write_enable), 64'd0);
        chk("fl.rdy", 64'(enq_ready), 64'd1);
        tick();
        flush = 1'b0; enq_valid = 1'b0;
        #1;
        chk("fl.cnt", 64'(queue_count), 64'd0);
        chk("fl.pm",  64'(pending_mask), 64'd0);
        chk("fl.fen2", 64'(force_reg_write_enable), 64'd0);

        // reset mid-stream
        set_block(1'b1);
        enq_one(4'd10, 64'hA);
        enq_one(4'd11, 64'hB);
        enq_one(4'd12, 64'hC);
        chk("pre.pm", 64'(pending_mask), 64'h1C00);
        set_block(1'b0);
        reset = 1'b1;
        #1;
        chk("rs.fen", 64'(force_reg_write_enable), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk_reset_vals("rs");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
